imme_ext_pipe: RTL
==================

# imme_ext_pipe

Pipelined, parametrised immediate generator for the decode stage. Accepts a 32-bit RISC-V instruction over a valid/ready handshake and classifies its format. Produces the sign- or zero-extended immediate at XLEN width, flags unsupported opcodes and keeps a saturating count of illegal instructions. A 2-entry skid buffer gives one cycle of latency and full throughput, with no combinational path from `out_ready` to `in_ready`.

## Interface
- `XLEN`, 32: immediate width; legal values are 32 and 64.
- `ZICSR`, 1: when 1, CSR immediate forms (SYSTEM, funct3[2]=1) use the zero-extended zimm format.
- `TAG_W`, 5: width of the sideband tag passed through unchanged.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  `in_inst`/`in_tag` are valid.
- `in_ready`  out  1  block can accept an entry.
- `in_inst`  in  32  instruction word.
- `in_tag`  in  TAG_W  sideband (e.g. PC bits or ROB id), returned with the result.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_imm`  out  XLEN  extended immediate.
- `out_fmt`  out  3  format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 none.
- `out_illegal`  out  1  opcode unsupported.
- `out_tag`  out  TAG_W  tag of the result.
- `illegal_cnt`  out  16  saturating count of illegal results transferred on the output.

## Operation
- Quadrant check: if `inst[1:0] != 2'b11`, the result is illegal.
- Decode on `inst[6:2]`:
  - I format (1): 00100, 00000, 11001, 00011. When XLEN=64, 00110 is also I.
  - SYSTEM 11100: Z (6) if ZICSR=1 and funct3[2]=1; otherwise I.
  - R format (0): 01100. When XLEN=64, 01110 is also R. R results have `out_imm`=0.
  - S format (2): 01000.
  - B format (3): 11000.
  - U format (4): 01101, 00101.
  - J format (5): 11011.
  - Every other opcode: fmt 7, `out_illegal`=1, `out_imm`=0. Every opcode must drive a value; no latch.
- Immediate construction:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - Z: inst[19:15], zero-extended.
  - All formats except Z sign-extend from inst[31] to XLEN. With XLEN=64, U is also sign-extended.
- Decode is combinational on the input side. The decoded entry is written into the buffer.
- Buffer: 2 entries, FIFO order, occupancy `count` in 0..2.
  - Accept occurs when `in_valid && in_ready`. Drain occurs when `out_valid && out_ready`.
  - `in_ready = (count != 2)`, taken from registered state only.
  - `out_valid = (count != 0)`. Output fields always show the head entry.
  - Accept and drain in the same cycle leave `count` unchanged.
  - When count is 2, `in_ready` is 0, so no accept can happen.
- `illegal_cnt`:
  - Increments by 1 on every drain with `out_illegal`=1.
  - Holds at 0xFFFF once reached; no wrap.
- Reset: `count`=0, `out_valid`=0, `out_imm`=0, `out_fmt`=0, `out_illegal`=0, `out_tag`=0, `illegal_cnt`=0. `in_ready`=0 while `rst` is high and 1 in the first cycle after.

## Timing
- Latency: an entry accepted at edge N is presented with `out_valid`=1 during the cycle after edge N.
- Throughput: 1 entry per cycle with `out_ready` held high.
- While `out_valid && !out_ready`, all output fields are held stable.
- `rst` asserted mid-operation discards both buffered entries at the next edge; no partial drain.
- Simultaneous drain and `rst`: reset wins, and `illegal_cnt` is cleared, not incremented.

## Test plan
- XLEN=32, send `0xFFF00093` (addi x1,x0,-1) -> one cycle later `out_imm`=0xFFFFFFFF, `out_fmt`=1, `out_illegal`=0.
- Send `0xFE112E23` (sw x1,-4(x2)) -> `out_imm`=0xFFFFFFFC, `out_fmt`=2. Send `0x3401D073` (csrrwi) -> `out_imm`=0x00000003, `out_fmt`=6.
- XLEN=64, send `0x800000B7` (lui x1,0x80000) -> `out_imm`=0xFFFFFFFF80000000, `out_fmt`=4.
- Hold `out_ready`=0 and offer tags 1, 2, 3 back-to-back -> tags 1 and 2 accepted, `in_ready`=0 from the next cycle, tag 3 stalled. Raise `out_ready` -> tags 1, 2, 3 emerge in order, one per cycle.
- Send `0x00000000`, then `0x0000007F` -> both emerge with `out_illegal`=1, `out_fmt`=7, `out_imm`=0; `illegal_cnt` reads 2 after both drains. Preload the count at 0xFFFF and drain one illegal entry -> count stays 0xFFFF.
- Fill both entries with `out_ready`=0, then pulse `rst` for 1 cycle -> next cycle `out_valid`=0, `illegal_cnt`=0; the following cycle `in_ready`=1 and a new entry emerges with 1-cycle latency.

Source files
------------

// File: rtl/imme_ext_pipe_if.sv
// Handshake bundle for the immediate generator: instruction in, decoded immediate out.
// The block uses the slave modport; the producer/consumer side uses master.
interface imme_ext_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_inst, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_inst, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );
endinterface

// File: rtl/imme_ext_pipe.sv
// RISC-V immediate generator: combinational decode into a 2-entry skid buffer,
// one cycle of latency, full throughput, saturating illegal-instruction counter.
module imme_ext_pipe #(
    parameter int XLEN  = 32,
    parameter bit ZICSR = 1'b1,
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    imme_ext_pipe_if.slave    bus,
    output logic [15:0]       illegal_cnt
);

    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;
    localparam logic [2:0] FMT_NONE = 3'd7;

    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        logic signed [XLEN-1:0] r;
        r = XLEN'(v);
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext5(input logic [4:0] v);
        return XLEN'(v);
    endfunction

    // ---- p0: combinational decode of the offered instruction ----
    logic [31:0]      inst_p0;
    logic [4:0]       op_p0;
    logic [2:0]       fmt_p0;
    logic [XLEN-1:0]  imm_p0;
    logic             ill_p0;
    logic             vld_p0;

    assign inst_p0 = bus.in_inst;
    assign op_p0   = inst_p0[6:2];

    always_comb begin
        fmt_p0 = FMT_NONE;
        case (op_p0)
            5'b00100, 5'b00000, 5'b11001, 5'b00011: fmt_p0 = FMT_I;
            5'b00110: fmt_p0 = (XLEN == 64) ? FMT_I : FMT_NONE;
            5'b11100: fmt_p0 = (ZICSR && inst_p0[14]) ? FMT_Z : FMT_I;
            5'b01100: fmt_p0 = FMT_R;
            5'b01110: fmt_p0 = (XLEN == 64) ? FMT_R : FMT_NONE;
            5'b01000: fmt_p0 = FMT_S;
            5'b11000: fmt_p0 = FMT_B;
            5'b01101, 5'b00101: fmt_p0 = FMT_U;
            5'b11011: fmt_p0 = FMT_J;
            default:  fmt_p0 = FMT_NONE;
        endcase
        // Compressed-quadrant encodings are not handled here.
        if (inst_p0[1:0] != 2'b11) fmt_p0 = FMT_NONE;
    end

    always_comb begin
        imm_p0 = '0;
        case (fmt_p0)
            FMT_I: imm_p0 = sext32({{20{inst_p0[31]}}, inst_p0[31:20]});
            FMT_S: imm_p0 = sext32({{20{inst_p0[31]}}, inst_p0[31:25], inst_p0[11:7]});
            FMT_B: imm_p0 = sext32({{19{inst_p0[31]}}, inst_p0[31], inst_p0[7],
                                    inst_p0[30:25], inst_p0[11:8], 1'b0});
            FMT_U: imm_p0 = sext32({inst_p0[31:12], 12'b0});
            FMT_J: imm_p0 = sext32({{11{inst_p0[31]}}, inst_p0[31], inst_p0[19:12],
                                    inst_p0[20], inst_p0[30:21], 1'b0});
            FMT_Z: imm_p0 = zext5(inst_p0[19:15]);
            default: imm_p0 = '0;
        endcase
    end

    assign ill_p0 = (fmt_p0 == FMT_NONE);

    // ---- p1: two-entry FIFO holding decoded results ----
    logic [XLEN-1:0]  imm_p1 [2];
    logic [2:0]       fmt_p1 [2];
    logic             ill_p1 [2];
    logic [TAG_W-1:0] tag_p1 [2];
    logic [1:0]       count_q;
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [15:0]      cnt_q;
    logic             vld_p1;
    logic             drn_p1;

    // in_ready depends on stored occupancy and rst only, never on out_ready.
    assign bus.in_ready = (count_q != 2'd2) && !rst;
    assign vld_p0       = bus.in_valid && bus.in_ready;
    assign vld_p1       = (count_q != 2'd0);
    assign drn_p1       = vld_p1 && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 16'd0;
            for (int i = 0; i < 2; i++) begin
                imm_p1[i] <= '0;
                fmt_p1[i] <= FMT_R;
                ill_p1[i] <= 1'b0;
                tag_p1[i] <= '0;
            end
        end else begin
            if (vld_p0) begin
                imm_p1[wr_ptr_q] <= imm_p0;
                fmt_p1[wr_ptr_q] <= fmt_p0;
                ill_p1[wr_ptr_q] <= ill_p0;
                tag_p1[wr_ptr_q] <= bus.in_tag;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (drn_p1) rd_ptr_q <= ~rd_ptr_q;
            if (vld_p0 && !drn_p1)
                count_q <= count_q + 2'd1;
            else if (!vld_p0 && drn_p1)
                count_q <= count_q - 2'd1;
            if (drn_p1 && ill_p1[rd_ptr_q] && (cnt_q != 16'hFFFF))
                cnt_q <= cnt_q + 16'd1;
        end
    end

    assign bus.out_valid   = vld_p1;
    assign bus.out_imm     = imm_p1[rd_ptr_q];
    assign bus.out_fmt     = fmt_p1[rd_ptr_q];
    assign bus.out_illegal = ill_p1[rd_ptr_q];
    assign bus.out_tag     = tag_p1[rd_ptr_q];
    assign illegal_cnt     = cnt_q;

endmodule
